// File: rtl/hwag_sync_ctrl.sv
// Crank sync engine for the hwag trigger wheel: measures tooth periods, finds the
// missing-tooth gap, numbers teeth and declares/revokes synchronisation.
module hwag_sync_ctrl #(
  parameter int unsigned TEETH   = 60,
  parameter int unsigned MISSING = 2,
  parameter int unsigned PW      = 24,
  parameter int unsigned TW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          edge_pulse,
  output logic          cap_ena,
  output logic [PW-1:0] period,
  output logic [TW-1:0] tooth,
  output logic          sync,
  output logic          gap_stb,
  output logic          sync_lost,
  output logic [2:0]    state
);

  localparam int unsigned N = TEETH - MISSING;
  localparam logic [TW-1:0] LAST    = TW'(N - 1);
  localparam logic [PW-1:0] CNT_MAX = '1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FIRST  = 3'd1;
  localparam logic [2:0] S_SEARCH = 3'd2;
  localparam logic [2:0] S_VERIFY = 3'd3;
  localparam logic [2:0] S_SYNC   = 3'd4;
  localparam logic [2:0] S_STALL  = 3'd5;

  logic [PW-1:0] cnt, cnt_nxt, period_nxt;
  logic [TW-1:0] tooth_nxt;
  logic [2:0]    state_nxt;
  logic          prev_valid, prev_valid_nxt, seen, seen_nxt;
  logic          sync_nxt, gap_stb_nxt, sync_lost_nxt, gap_c;

  // Gap: current interval at least twice the last completed one, compared without overflow.
  assign gap_c = prev_valid && ({1'b0, cnt} >= {period, 1'b0});

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = (cnt == CNT_MAX) ? cnt : cnt + PW'(1);
    period_nxt     = period;
    tooth_nxt      = tooth;
    sync_nxt       = sync;
    gap_stb_nxt    = 1'b0;
    sync_lost_nxt  = 1'b0;
    prev_valid_nxt = prev_valid;
    seen_nxt       = seen;

    if (!start) begin
      state_nxt      = S_IDLE;
      cnt_nxt        = '0;
      tooth_nxt      = '0;
      sync_nxt       = 1'b0;
      prev_valid_nxt = 1'b0;
      seen_nxt       = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_FIRST;
          cnt_nxt   = '0;
        end
        S_FIRST, S_SEARCH, S_VERIFY, S_SYNC, S_STALL: begin
          if (edge_pulse) begin
            cnt_nxt    = PW'(1);
            period_nxt = cnt;
            seen_nxt   = 1'b1;
            if (seen) prev_valid_nxt = 1'b1;
            case (state)
              S_SEARCH: begin
                if (gap_c) begin
                  state_nxt   = S_VERIFY;
                  tooth_nxt   = '0;
                  gap_stb_nxt = 1'b1;
                end
              end
              S_VERIFY: begin
                if (gap_c && tooth == LAST) begin
                  state_nxt   = S_SYNC;
                  tooth_nxt   = '0;
                  sync_nxt    = 1'b1;
                  gap_stb_nxt = 1'b1;
                end else if (gap_c || tooth == LAST) begin
                  state_nxt = S_SEARCH;
                  tooth_nxt = '0;
                end else begin
                  tooth_nxt = tooth + TW'(1);
                end
              end
              S_SYNC: begin
                if (gap_c && tooth == LAST) begin
                  tooth_nxt   = '0;
                  gap_stb_nxt = 1'b1;
                end else if (gap_c || tooth == LAST) begin
                  state_nxt     = S_SEARCH;
                  tooth_nxt     = '0;
                  sync_nxt      = 1'b0;
                  sync_lost_nxt = 1'b1;
                end else begin
                  tooth_nxt = tooth + TW'(1);
                end
              end
              default: begin
                state_nxt = S_SEARCH;
                tooth_nxt = '0;
              end
            endcase
          end else if (cnt == CNT_MAX && state != S_STALL) begin
            // Wheel stopped: drop sync and restart period history from scratch.
            state_nxt      = S_STALL;
            sync_nxt       = 1'b0;
            sync_lost_nxt  = (state == S_SYNC);
            prev_valid_nxt = 1'b0;
            seen_nxt       = 1'b0;
            tooth_nxt      = '0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      period     <= '0;
      tooth      <= '0;
      sync       <= 1'b0;
      gap_stb    <= 1'b0;
      sync_lost  <= 1'b0;
      cap_ena    <= 1'b0;
      prev_valid <= 1'b0;
      seen       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      period     <= period_nxt;
      tooth      <= tooth_nxt;
      sync       <= sync_nxt;
      gap_stb    <= gap_stb_nxt;
      sync_lost  <= sync_lost_nxt;
      cap_ena    <= (state_nxt != S_IDLE);
      prev_valid <= prev_valid_nxt;
      seen       <= seen_nxt;
    end
  end

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// Directed bench for hwag_sync_ctrl on an 8-2 wheel with an 8-bit period counter.
module tb_hwag_sync_ctrl;

  localparam int unsigned PW = 8;
  localparam int unsigned TW = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FIRST  = 3'd1;
  localparam logic [2:0] S_SEARCH = 3'd2;
  localparam logic [2:0] S_VERIFY = 3'd3;
  localparam logic [2:0] S_SYNC   = 3'd4;
  localparam logic [2:0] S_STALL  = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          edge_pulse = 1'b0;
  logic          cap_ena;
  logic [PW-1:0] period;
  logic [TW-1:0] tooth;
  logic          sync, gap_stb, sync_lost;
  logic [2:0]    state;

  hwag_sync_ctrl #(.TEETH(8), .MISSING(2), .PW(PW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .edge_pulse(edge_pulse),
    .cap_ena(cap_ena), .period(period), .tooth(tooth), .sync(sync),
    .gap_stb(gap_stb), .sync_lost(sync_lost), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned gap;     // clk from previous edge to this edge
    logic        start;
    logic [2:0]  s;
    int unsigned t;
    logic        sy, gs, sl, ce;
    int unsigned per;
    logic        chk_per;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int unsigned gap, input logic st, input logic [2:0] s,
                               input int unsigned t, input logic sy, input logic gs,
                               input logic sl, input logic ce, input int unsigned per,
                               input logic cp);
    vec_t v;
    v.gap = gap; v.start = st; v.s = s; v.t = t; v.sy = sy; v.gs = gs;
    v.sl = sl; v.ce = ce; v.per = per; v.chk_per = cp;
    vecs.push_back(v);
  endfunction

  // First edge, two teeth, gap into VERIFY, five teeth, gap into SYNC.
  function automatic void push_acquire(input logic from_stall);
    push(10, 1, S_SEARCH, 0, 0, 0, 0, 1, from_stall ? 255 : 0, from_stall);
    push(10, 1, S_SEARCH, 0, 0, 0, 0, 1, 10, 1);
    push(10, 1, S_SEARCH, 0, 0, 0, 0, 1, 10, 1);
    push(30, 1, S_VERIFY, 0, 0, 1, 0, 1, 30, 1);
    for (int t = 1; t <= 5; t++) push(10, 1, S_VERIFY, t, 0, 0, 0, 1, 10, 1);
    push(30, 1, S_SYNC, 0, 1, 1, 0, 1, 30, 1);
  endfunction

  task automatic run_rows(input int lo, input int hi);
    vec_t v;
    for (int i = lo; i < hi; i++) begin
      v = vecs[i];
      repeat (v.gap - 2) tick();
      start = v.start;
      edge_pulse = 1'b1;
      tick();
      edge_pulse = 1'b0;
      chk($sformatf("row%0d state", i), state, v.s);
      chk($sformatf("row%0d tooth", i), tooth, v.t);
      chk($sformatf("row%0d sync", i), sync, v.sy);
      chk($sformatf("row%0d gap_stb", i), gap_stb, v.gs);
      chk($sformatf("row%0d sync_lost", i), sync_lost, v.sl);
      chk($sformatf("row%0d cap_ena", i), cap_ena, v.ce);
      if (v.chk_per) chk($sformatf("row%0d period", i), period, v.per);
      tick();
      chk($sformatf("row%0d gap_stb_drop", i), gap_stb, 0);
      chk($sformatf("row%0d sync_lost_drop", i), sync_lost, 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " state"}, state, 0);
    chk({tag, " cap_ena"}, cap_ena, 0);
    chk({tag, " period"}, period, 0);
    chk({tag, " tooth"}, tooth, 0);
    chk({tag, " sync"}, sync, 0);
    chk({tag, " gap_stb"}, gap_stb, 0);
    chk({tag, " sync_lost"}, sync_lost, 0);
  endtask

  initial begin
    int b0, b1, b2, b3;

    // Segment 0: edges while stopped are ignored.
    for (int i = 0; i < 3; i++) push(10, 0, S_IDLE, 0, 0, 0, 0, 0, 0, 1);
    b0 = vecs.size();
    // Segment 1: acquire, track 3 revolutions, lose sync at tooth 3, re-acquire.
    push_acquire(0);
    for (int r = 0; r < 3; r++) begin
      for (int t = 1; t <= 5; t++) push(10, 1, S_SYNC, t, 1, 0, 0, 1, 10, 1);
      push(30, 1, S_SYNC, 0, 1, 1, 0, 1, 30, 1);
    end
    for (int t = 1; t <= 3; t++) push(10, 1, S_SYNC, t, 1, 0, 0, 1, 10, 1);
    push(30, 1, S_SEARCH, 0, 0, 0, 1, 1, 30, 1);
    push(10, 1, S_SEARCH, 0, 0, 0, 0, 1, 10, 1);
    push(10, 1, S_SEARCH, 0, 0, 0, 0, 1, 10, 1);
    push(30, 1, S_VERIFY, 0, 0, 1, 0, 1, 30, 1);
    for (int t = 1; t <= 5; t++) push(10, 1, S_VERIFY, t, 0, 0, 0, 1, 10, 1);
    push(30, 1, S_SYNC, 0, 1, 1, 0, 1, 30, 1);
    for (int t = 1; t <= 2; t++) push(10, 1, S_SYNC, t, 1, 0, 0, 1, 10, 1);
    b1 = vecs.size();
    // Segment 2: recovery after stall, then stop on the same clk as an edge.
    push_acquire(1);
    for (int t = 1; t <= 2; t++) push(10, 1, S_SYNC, t, 1, 0, 0, 1, 10, 1);
    push(20, 0, S_IDLE, 0, 0, 0, 0, 0, 10, 1);
    b2 = vecs.size();
    // Segment 3: acquire again ahead of the async reset check.
    push_acquire(0);
    b3 = vecs.size();

    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();
    chk_all_zero("idle_start0");

    run_rows(0, b0);

    start = 1'b1;
    tick();
    chk("first state", state, S_FIRST);
    chk("first cap_ena", cap_ena, 1);
    run_rows(b0, b1);

    // Last edge was one tick ago; the counter saturates 255 clk after it.
    repeat (253) tick();
    chk("pre_stall state", state, S_SYNC);
    chk("pre_stall sync", sync, 1);
    tick();
    chk("stall state", state, S_STALL);
    chk("stall sync_lost", sync_lost, 1);
    chk("stall sync", sync, 0);
    chk("stall tooth", tooth, 0);
    chk("stall cap_ena", cap_ena, 1);
    tick();
    chk("stall sync_lost_drop", sync_lost, 0);
    chk("stall hold", state, S_STALL);
    run_rows(b1, b2);

    start = 1'b1;
    tick();
    chk("restart state", state, S_FIRST);
    run_rows(b2, b3);

    chk("pre_reset sync", sync, 1);
    #3;
    rst = 1'b0;
    #2;
    chk_all_zero("async_reset");
    tick();
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hwag_sync_ctrl.md
Name: hwag_sync_ctrl

Overview:
- Sequences the hwag trigger-wheel capture path.
- Enables the VR capture stage and measures the period between filtered edge pulses.
- Detects the missing-tooth gap, numbers the teeth, and declares or revokes crank synchronisation for downstream angle generation.
- Sits between the capture/filter stage (edge pulse in, capture enable out) and the angle/compare logic. Control comes from a bit in the ssram-mapped control register.

Parameters:
- TEETH, 60, nominal tooth positions per revolution, including missing ones.
- MISSING, 2, number of missing teeth in the gap; real edges per revolution N = TEETH-MISSING.
- PW, 24, period counter and period output width.
- TW, 8, tooth counter width; requires 2^TW > N.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  level; 1 = run the sync engine, 0 = stop (from control register).
- edge  in  1  one-clk pulse per selected filtered VR edge.
- cap_ena  out  1  capture output enable to the filter stage.
- period  out  PW  clk count of the last completed tooth interval.
- tooth  out  TW  current tooth number; 0 = edge that ends the gap.
- sync  out  1  crank synchronised.
- gap_stb  out  1  one-clk pulse when an accepted gap edge is registered.
- sync_lost  out  1  one-clk pulse on loss of sync or stall.
- state  out  3  current FSM state (debug/status readback).

Behaviour:
- Reset (rst=0, async):
  - All outputs 0 and state=IDLE.
  - Period counter cnt=0, prev_period=0, prev_valid=0.
- Period measurement:
  - On edge, cnt loads 1; otherwise cnt increments, saturating at 2^PW-1.
  - On edge, period<=cnt and prev_period<=period. Edges at cycles a and b therefore give period=b-a.
  - prev_valid is set after the second edge since leaving IDLE.
- Gap test (edge cycle, prev_valid=1): gap = (cnt >= 2*prev_period), compared at PW+1 bits with no overflow.
- Outputs are registered: edge at cycle n updates period, tooth, sync, gap_stb and sync_lost at n+1.
- cap_ena = 1 in every state except IDLE, also registered.
- States:
  - IDLE: start=1 -> FIRST.
  - FIRST: first edge -> SEARCH; cnt starts.
  - SEARCH: edge with gap -> VERIFY, tooth<=0, gap_stb=1. Non-gap edges only update period.
  - VERIFY: non-gap edge -> tooth++. At a gap edge:
    - if tooth==N-1 -> SYNC, tooth<=0, sync<=1, gap_stb=1;
    - else -> SEARCH with tooth<=0.
    - A non-gap edge with tooth==N-1 -> SEARCH.
  - SYNC: non-gap edge with tooth<N-1 -> tooth++. Loss of sync (sync<=0, sync_lost=1, state SEARCH, tooth<=0) on either:
    - a gap edge with tooth!=N-1;
    - a non-gap edge with tooth==N-1.
    - Gap edge with tooth==N-1 -> tooth<=0, gap_stb=1, stays SYNC.
  - STALL: entered from FIRST, SEARCH, VERIFY or SYNC when cnt saturates.
    - Effects: sync<=0, sync_lost=1 only if previously SYNC, prev_valid<=0, tooth<=0.
    - Next edge -> SEARCH with cnt=1; this edge counts as first.
- start=0 in any state forces IDLE next cycle, even with a simultaneous edge:
  - clears sync, tooth, prev_valid;
  - no sync_lost pulse;
  - period keeps its last value.
- Edges while in IDLE are ignored. Edge and saturation in the same cycle: the edge wins, cnt loads 1, and period=2^PW-1.
- tooth never exceeds N-1. State encoding: IDLE=0, FIRST=1, SEARCH=2, VERIFY=3, SYNC=4, STALL=5.

Test Plan:
- Reset/idle: rst low mid-run with sync=1 -> all outputs 0 immediately. With start=0, edges every 10 clk -> state stays 0, cap_ena=0.
- Acquire: TEETH=8, MISSING=2, start=1. Edges 10 clk apart, gap interval 30 clk.
  - 1st gap -> state 3, gap_stb.
  - 5 teeth later the 2nd gap -> sync=1 one clk after the edge, tooth=0, period=30.
- Tracking: continue the same wheel for 3 revolutions.
  - tooth sequence 0..5 repeating, sync stays 1, gap_stb every 6th edge, period=10 on teeth.
- Loss of sync: in SYNC, inject a 30-clk gap at tooth 3.
  - sync_lost pulse, sync=0, state=2, tooth=0. Re-acquires after two correct revolutions.
- Stall: PW=8, in SYNC stop edges.
  - 255 clk after the last edge: state=5, sync_lost pulse, sync=0.
  - Next edge -> state 2.
- Stop with simultaneous edge: start drops on the same clk as an edge while in SYNC.
  - state=0, sync=0, cap_ena=0 next clk, no sync_lost, period unchanged.
